line_wb_bridge: RTL and testbench
=================================

LINE_WB_BRIDGE -- requirements
Module: line_wb_bridge

Interface
REQ-001 SHALL have parameter WB_ADDR_BASE, default 32'h3000_0000, OR-ed into every Wishbone byte address.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum wait in cycles per beat; 0 disables the timeout.
REQ-003 clock  in  1  sole clock; all flops rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  line request strobe; one-cycle pulse from the cache miss path.
REQ-006 req_info  in  149  [148:129] line address (byte addr >> 4), [128] write flag, [127:0] write line.
REQ-007 req_ready  out  1  high only in IDLE.
REQ-008 rsp_valid  out  1  one-cycle completion pulse.
REQ-009 rsp_data  out  128  read line; zero for writes and on error.
REQ-010 rsp_bus_error  out  1  qualifies rsp_valid; set on wbm_err_i or timeout.
REQ-011 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-012 wbm_sel_o  out  4  always 4'hF while stb is high, else 0.
REQ-013 wbm_adr_o  out  32; wbm_dat_o  out  32; wbm_dat_i  in  32; wbm_ack_i  in  1; wbm_err_i  in  1.

Function
REQ-014 SHALL implement FSM states IDLE, XFER, RESP.
REQ-015 IDLE: on req_valid, latch req_info, clear beat counter, clear timeout counter, clear the rsp_data accumulator, and go to XFER next cycle.
REQ-016 req_valid outside IDLE SHALL be ignored without state change; the bench flags it as a protocol violation.
REQ-017 XFER: cyc=stb=1, we=latched write flag, adr = WB_ADDR_BASE | {8'b0, line_addr, beat[1:0], 2'b00}, dat_o = line[32*beat +: 32].
REQ-018 XFER on ack with no err: a read stores wbm_dat_i into the accumulator at [32*beat +: 32]; if beat<3, increment beat and stay in XFER, keeping stb high with the new address next cycle; if beat==3, go to RESP.
REQ-019 XFER on err: go to RESP with error set; err has priority when ack and err are simultaneous; remaining beats SHALL NOT be issued.
REQ-020 Timeout counter resets on every ack; if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no ack or err, go to RESP with error set.
REQ-021 RESP: cyc=stb=0, rsp_valid=1 for exactly one cycle, rsp_bus_error=error flag; next state IDLE.
REQ-022 rsp_data SHALL be the accumulator for an error-free read, otherwise 128'h0; it is held stable until the next request is accepted.
REQ-023 Latency: request accepted in cycle N with zero-wait ack gives beats at N+1..N+4, rsp_valid at N+5, and req_ready high again at N+6.
REQ-024 The line address SHALL be used unmodified (20 bits); the beat counter SHALL be 2 bits and never wrap within a request.
REQ-025 Outputs SHALL be registered or decoded from state/registers only, with no combinational path from wbm_ack_i to wbm_stb_o.

Reset
REQ-026 Reset asserted SHALL force IDLE immediately: cyc/stb/we/sel/rsp_valid/rsp_bus_error=0, rsp_data=0, adr/dat_o=0, req_ready=1 after reset release, counters=0.
REQ-027 Reset mid-transfer SHALL abort the transfer with no rsp_valid generated.

Structure
REQ-028 Package line_wb_bridge_pkg SHALL hold the state enum, req_info field offsets (ADDR_MSB=148, ADDR_LSB=129, WR_BIT=128), BEATS=4, and LINE_BITS=128.
REQ-029 The block SHALL be flat, with no sub-module; the timeout counter is inline.

Verification
REQ-030 Read, line 20'h00012, zero-wait slave returning 32'h11111111..44444444 -> adr 0x30000120/124/128/12C, rsp_valid at N+5, rsp_data=128'h44444444_33333333_22222222_11111111, rsp_bus_error=0.
REQ-031 Write, line 20'h00001, data 128'hDDDD_CCCC_BBBB_AAAA (word-wise) -> beats with we=1, dat_o per word at adr 0x30000010..1C, rsp_valid with rsp_data=0, rsp_bus_error=0.
REQ-032 Read with err on beat 2 (ack and err both high) -> exactly 3 stb beats issued, rsp_bus_error=1, rsp_data=0.
REQ-033 TIMEOUT_CYCLES=8, slave never acks -> rsp_valid with rsp_bus_error=1 eight cycles after stb rises, cyc low in RESP.
REQ-034 Reset asserted during beat 1 of a read -> cyc/stb drop without waiting for a clock edge, no rsp_valid, req_ready=1 after release, and the next request completes normally.
REQ-035 Slave with 3 wait states per beat plus a second req_valid pulse during XFER -> the second pulse is ignored, and rsp_valid occurs exactly once at N+17.

Source files
------------

// File: rtl/line_wb_bridge_pkg.sv
// Shared types and field layout for the cache-line to Wishbone classic bridge.
package line_wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  // req_info layout: {line_addr[19:0], write_flag, write_line[127:0]}
  localparam int ADDR_MSB  = 148;
  localparam int ADDR_LSB  = 129;
  localparam int WR_BIT    = 128;
  localparam int BEATS     = 4;
  localparam int LINE_BITS = 128;
  localparam int REQ_BITS  = ADDR_MSB + 1;
  localparam int WORD_BITS = LINE_BITS / BEATS;

endpackage

// File: rtl/line_wb_bridge.sv
// Moves one 128-bit cache line over a 32-bit Wishbone classic master as four
// single-word beats, with a per-beat timeout and a one-cycle completion pulse.
module line_wb_bridge
  import line_wb_bridge_pkg::*;
#(
  parameter logic [31:0] WB_ADDR_BASE   = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [REQ_BITS-1:0]  req_info,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [LINE_BITS-1:0] rsp_data,
  output logic                 rsp_bus_error,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic [1:0]           state_dbg
);

  // Handshake: a request is taken on any cycle where req_valid && req_ready;
  // rsp_valid is a single-cycle pulse with no back-pressure, and each Wishbone
  // beat completes on the first cycle stb is high together with ack or err.

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_e                 state;
  logic [19:0]            addr_q;
  logic                   wr_q;
  logic [LINE_BITS-1:0]   line_q;
  logic [1:0]             beat_q;
  logic [TW-1:0]          tmo_q;
  logic                   err_q;
  logic [LINE_BITS-1:0]   acc_q;
  logic [LINE_BITS-1:0]   rsp_data_q;
  logic                   xfer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      line_q     <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_info[ADDR_MSB:ADDR_LSB];
            wr_q   <= req_info[WR_BIT];
            line_q <= req_info[LINE_BITS-1:0];
            beat_q <= '0;
            tmo_q  <= '0;
            err_q  <= 1'b0;
            acc_q  <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          // err wins over a simultaneous ack and abandons the remaining beats.
          if (wbm_err_i) begin
            err_q      <= 1'b1;
            rsp_data_q <= '0;
            state      <= RESP;
          end else if (wbm_ack_i) begin
            tmo_q <= '0;
            if (!wr_q) acc_q[WORD_BITS*beat_q +: WORD_BITS] <= wbm_dat_i;
            if (beat_q == LAST_BEAT) begin
              rsp_data_q <= wr_q ? '0 : {wbm_dat_i, acc_q[LINE_BITS-WORD_BITS-1:0]};
              state      <= RESP;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end else if (TMO_EN) begin
            if (tmo_q == TMO_LAST) begin
              err_q      <= 1'b1;
              rsp_data_q <= '0;
              state      <= RESP;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All bus and response outputs decode from registered state only.
  assign xfer          = (state == XFER);
  assign req_ready     = (state == IDLE);
  assign rsp_valid     = (state == RESP);
  assign rsp_bus_error = rsp_valid & err_q;
  assign rsp_data      = rsp_data_q;
  assign wbm_cyc_o     = xfer;
  assign wbm_stb_o     = xfer;
  assign wbm_we_o      = xfer & wr_q;
  assign wbm_sel_o     = xfer ? 4'hF : 4'h0;
  assign wbm_adr_o     = xfer ? (WB_ADDR_BASE | {8'b0, addr_q, beat_q, 2'b00}) : 32'h0;
  assign wbm_dat_o     = xfer ? line_q[WORD_BITS*beat_q +: WORD_BITS] : 32'h0;
  assign state_dbg     = state;

endmodule

// File: tb/tb_line_wb_bridge.sv
// Bench for line_wb_bridge: behavioural Wishbone slave, response monitor and a
// line-level reference model checked against directed and random requests.
module tb_line_wb_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TMO  = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT ----------------
  logic         req_valid;
  logic [148:0] req_info;
  logic         req_ready, rsp_valid, rsp_bus_error;
  logic [127:0] rsp_data;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o;
  logic [31:0]  wbm_dat_i = '0;
  logic         wbm_ack_i = 1'b0;
  logic         wbm_err_i = 1'b0;
  logic [1:0]   state_dbg;

  line_wb_bridge #(.WB_ADDR_BASE(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_info(req_info), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_bus_error(rsp_bus_error),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int passed = 0;

  // ---------------- slave configuration and logs ----------------
  int          wait_states = 0;
  int          err_beat    = -1;
  bit          err_with_ack = 1'b0;
  bit          no_ack      = 1'b0;
  logic [31:0] rd_words [4];
  int          beats_seen  = 0;
  int          stb_cycles  = 0;
  int          wcnt        = 0;
  int          proto_viol  = 0;
  int          ready_cyc   = -1;
  bit          await_ready = 1'b0;

  logic [31:0] beat_adr_q[$];
  logic [31:0] beat_dat_q[$];
  logic        beat_we_q[$];
  logic [3:0]  beat_sel_q[$];
  int          rsp_cyc_q[$];
  logic [127:0] rsp_dat_q[$];
  logic        rsp_err_q[$];
  logic        rsp_wbcyc_q[$];
  logic [31:0] exp_q[$];

  // Slave drives ack/err for the next rising edge; monitor logs responses.
  always @(negedge clock) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    if (reset || !wbm_stb_o) begin
      wcnt = 0;
    end else begin
      stb_cycles++;
      if (!no_ack && wcnt == wait_states) begin
        wcnt = 0;
        beat_adr_q.push_back(wbm_adr_o);
        beat_dat_q.push_back(wbm_dat_o);
        beat_we_q.push_back(wbm_we_o);
        beat_sel_q.push_back(wbm_sel_o);
        wbm_dat_i = rd_words[wbm_adr_o[3:2]];
        if (beats_seen == err_beat) begin
          wbm_err_i = 1'b1;
          wbm_ack_i = err_with_ack;
        end else begin
          wbm_ack_i = 1'b1;
        end
        beats_seen++;
      end else begin
        wcnt++;
      end
    end
    if (rsp_valid === 1'b1) begin
      rsp_cyc_q.push_back(cyc_cnt);
      rsp_dat_q.push_back(rsp_data);
      rsp_err_q.push_back(rsp_bus_error);
      rsp_wbcyc_q.push_back(wbm_cyc_o);
      await_ready = 1'b1;
    end else if (await_ready && req_ready === 1'b1) begin
      ready_cyc   = cyc_cnt;
      await_ready = 1'b0;
    end
  end

  always @(posedge clock) begin
    if (!reset && req_valid === 1'b1 && req_ready !== 1'b1) begin
      proto_viol++;
      $display("note: req_valid while bridge busy (cycle %0d), expected to be ignored", cyc_cnt);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_adr(input logic [19:0] a, input int beat);
    return BASE | (32'(a) << 4) | 32'(beat * 4);
  endfunction

  function automatic logic [127:0] exp_read_line();
    return {rd_words[3], rd_words[2], rd_words[1], rd_words[0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [19:0] a, input logic w, input logic [127:0] line,
                       output int n_acc);
    int guard = 0;
    beat_adr_q.delete(); beat_dat_q.delete(); beat_we_q.delete(); beat_sel_q.delete();
    rsp_cyc_q.delete(); rsp_dat_q.delete(); rsp_err_q.delete(); rsp_wbcyc_q.delete();
    beats_seen = 0; stb_cycles = 0; ready_cyc = -1;
    @(negedge clock);
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if (req_ready !== 1'b1) $display("FAIL issue_ready: req_ready=%b, required 1", req_ready);
    else passed++;
    req_info  = {a, w, line};
    req_valid = 1'b1;
    n_acc     = cyc_cnt;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clock);
      if (rsp_cyc_q.size() != 0) got = 1'b1;
    end
    repeat (20) @(posedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid, rsp_bus_error} !== 9'b0)
      $display("FAIL reset_ctl: cyc/stb/we/sel/rsp_valid/err=%b, required 0",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid, rsp_bus_error});
    else passed++;
    checks++;
    if ({wbm_adr_o, wbm_dat_o} !== 64'h0)
      $display("FAIL reset_bus: adr=%h dat=%h, required 0", wbm_adr_o, wbm_dat_o);
    else passed++;
    checks++;
    if (rsp_data !== 128'h0) $display("FAIL reset_rsp_data: %h, required 0", rsp_data);
    else passed++;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    else passed++;
  endtask

  task automatic test_read_basic();
    int n; bit got;
    rd_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    wait_states = 0; err_beat = -1; no_ack = 1'b0;
    issue(20'h00012, 1'b0, 128'h0, n);
    wait_rsp(got);
    checks++;
    if (!got) $display("FAIL rd_rsp_seen: no rsp_valid within bound, required one");
    else passed++;
    checks++;
    if (beat_adr_q.size() != 4) $display("FAIL rd_beats: %0d beats, required 4", beat_adr_q.size());
    else passed++;
    for (int i = 0; i < 4 && i < beat_adr_q.size(); i++) begin
      checks++;
      if (beat_adr_q[i] !== exp_adr(20'h00012, i) || beat_we_q[i] !== 1'b0 || beat_sel_q[i] !== 4'hF)
        $display("FAIL rd_beat%0d: adr=%h we=%b sel=%h, required adr=%h we=0 sel=f",
                 i, beat_adr_q[i], beat_we_q[i], beat_sel_q[i], exp_adr(20'h00012, i));
      else passed++;
    end
    if (got) begin
      checks++;
      if (rsp_cyc_q[0] != n + 5) $display("FAIL rd_latency: rsp at N+%0d, required N+5", rsp_cyc_q[0] - n);
      else passed++;
      checks++;
      if (rsp_dat_q[0] !== 128'h44444444_33333333_22222222_11111111 || rsp_err_q[0] !== 1'b0)
        $display("FAIL rd_data: data=%h err=%b, required 44444444333333332222222211111111 err=0",
                 rsp_dat_q[0], rsp_err_q[0]);
      else passed++;
      checks++;
      if (ready_cyc != n + 6) $display("FAIL rd_ready_again: ready at N+%0d, required N+6", ready_cyc - n);
      else passed++;
    end
  endtask

  task automatic test_write_basic();
    int n; bit got;
    logic [127:0] line;
    line = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    wait_states = 0; err_beat = -1; no_ack = 1'b0;
    issue(20'h00001, 1'b1, line, n);
    wait_rsp(got);
    checks++;
    if (beat_adr_q.size() != 4) $display("FAIL wr_beats: %0d beats, required 4", beat_adr_q.size());
    else passed++;
    for (int i = 0; i < 4 && i < beat_adr_q.size(); i++) begin
      checks++;
      if (beat_adr_q[i] !== 32'h30000010 + 32'(4 * i) || beat_we_q[i] !== 1'b1 ||
          beat_dat_q[i] !== line[32*i +: 32])
        $display("FAIL wr_beat%0d: adr=%h we=%b dat=%h, required adr=%h we=1 dat=%h",
                 i, beat_adr_q[i], beat_we_q[i], beat_dat_q[i], 32'h30000010 + 32'(4 * i), line[32*i +: 32]);
      else passed++;
    end
    checks++;
    if (!got || rsp_dat_q[0] !== 128'h0 || rsp_err_q[0] !== 1'b0 || rsp_cyc_q[0] != n + 5)
      $display("FAIL wr_rsp: seen=%b data=%h err=%b, required seen=1 data=0 err=0 at N+5",
               got, got ? rsp_dat_q[0] : 128'h0, got ? rsp_err_q[0] : 1'b0);
    else passed++;
  endtask

  task automatic test_err_beat();
    int n; bit got;
    rd_words = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f00};
    wait_states = 0; err_beat = 2; err_with_ack = 1'b1; no_ack = 1'b0;
    issue(20'h0BEEF, 1'b0, 128'h0, n);
    wait_rsp(got);
    checks++;
    if (beat_adr_q.size() != 3 || stb_cycles != 3)
      $display("FAIL err_beats: beats=%0d stb_cycles=%0d, required 3 and 3", beat_adr_q.size(), stb_cycles);
    else passed++;
    checks++;
    if (!got || rsp_err_q[0] !== 1'b1 || rsp_dat_q[0] !== 128'h0 || rsp_cyc_q.size() != 1)
      $display("FAIL err_rsp: seen=%b count=%0d err=%b data=%h, required one rsp err=1 data=0",
               got, rsp_cyc_q.size(), got ? rsp_err_q[0] : 1'b0, got ? rsp_dat_q[0] : 128'h0);
    else passed++;
    err_beat = -1; err_with_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int n; bit got;
    wait_states = 0; err_beat = -1; no_ack = 1'b1;
    issue(20'h00777, 1'b0, 128'h0, n);
    wait_rsp(got);
    checks++;
    if (!got) $display("FAIL tmo_rsp_seen: no rsp_valid within bound, required one");
    else passed++;
    if (got) begin
      checks++;
      if (rsp_cyc_q[0] != n + 1 + TMO)
        $display("FAIL tmo_latency: rsp %0d cycles after stb rise, required %0d", rsp_cyc_q[0] - n - 1, TMO);
      else passed++;
      checks++;
      if (rsp_err_q[0] !== 1'b1 || rsp_wbcyc_q[0] !== 1'b0 || rsp_dat_q[0] !== 128'h0)
        $display("FAIL tmo_rsp: err=%b cyc=%b data=%h, required err=1 cyc=0 data=0",
                 rsp_err_q[0], rsp_wbcyc_q[0], rsp_dat_q[0]);
      else passed++;
    end
    checks++;
    if (stb_cycles != TMO) $display("FAIL tmo_stb_cycles: %0d, required %0d", stb_cycles, TMO);
    else passed++;
    no_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n; bit got;
    rd_words = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    wait_states = 0; err_beat = -1; no_ack = 1'b0;
    issue(20'h0ABCD, 1'b0, 128'h0, n);
    @(negedge clock);
    checks++;
    if (wbm_stb_o !== 1'b1 || wbm_adr_o !== exp_adr(20'h0ABCD, 1))
      $display("FAIL rstmid_beat1: stb=%b adr=%h, required stb=1 adr=%h", wbm_stb_o, wbm_adr_o, exp_adr(20'h0ABCD, 1));
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0)
      $display("FAIL rstmid_async: cyc=%b stb=%b before clock edge, required 0", wbm_cyc_o, wbm_stb_o);
    else passed++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    checks++;
    if (rsp_cyc_q.size() != 0 || req_ready !== 1'b1)
      $display("FAIL rstmid_abort: rsp count=%0d ready=%b, required 0 and 1", rsp_cyc_q.size(), req_ready);
    else passed++;
    issue(20'h00321, 1'b0, 128'h0, n);
    wait_rsp(got);
    checks++;
    if (!got || rsp_dat_q[0] !== exp_read_line() || rsp_err_q[0] !== 1'b0 || rsp_cyc_q[0] != n + 5)
      $display("FAIL rstmid_next: seen=%b data=%h, required data=%h err=0 at N+5",
               got, got ? rsp_dat_q[0] : 128'h0, exp_read_line());
    else passed++;
  endtask

  task automatic test_ignore_busy();
    int n; int v0; bit got;
    rd_words = '{32'h00C0FFEE, 32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0};
    wait_states = 3; err_beat = -1; no_ack = 1'b0;
    v0 = proto_viol;
    issue(20'h04444, 1'b0, 128'h0, n);
    repeat (3) @(negedge clock);
    req_info  = {20'h05555, 1'b1, 128'hFFFF};
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    wait_rsp(got);
    checks++;
    if (rsp_cyc_q.size() != 1 || (got && rsp_cyc_q[0] != n + 17))
      $display("FAIL busy_rsp: count=%0d at N+%0d, required one at N+17",
               rsp_cyc_q.size(), got ? rsp_cyc_q[0] - n : -1);
    else passed++;
    checks++;
    if (!got || rsp_dat_q[0] !== exp_read_line() || beat_adr_q.size() != 4)
      $display("FAIL busy_data: data=%h beats=%0d, required %h and 4",
               got ? rsp_dat_q[0] : 128'h0, beat_adr_q.size(), exp_read_line());
    else passed++;
    for (int i = 0; i < beat_adr_q.size(); i++) begin
      checks++;
      if (beat_adr_q[i] !== exp_adr(20'h04444, i) || beat_we_q[i] !== 1'b0)
        $display("FAIL busy_beat%0d: adr=%h we=%b, required %h we=0", i, beat_adr_q[i], beat_we_q[i], exp_adr(20'h04444, i));
      else passed++;
    end
    checks++;
    if (proto_viol - v0 != 1) $display("FAIL busy_flag: %0d busy pulses seen, required 1", proto_viol - v0);
    else passed++;
    wait_states = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      int n; int nb; int exp_cyc; bit got;
      logic [19:0] a; logic w; logic [127:0] line; logic [127:0] exp_data; logic exp_err;
      a    = 20'($urandom_range(0, 20'hFFFFF));
      w    = 1'($urandom_range(0, 1));
      line = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++) rd_words[k] = $urandom;
      wait_states  = $urandom_range(0, 3);
      err_beat     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      err_with_ack = 1'($urandom_range(0, 1));
      no_ack       = 1'b0;
      nb       = (err_beat >= 0) ? err_beat + 1 : 4;
      exp_err  = (err_beat >= 0);
      exp_data = (w || exp_err) ? 128'h0 : exp_read_line();
      exp_q.delete();
      for (int i = 0; i < nb; i++) exp_q.push_back(exp_adr(a, i));
      issue(a, w, line, n);
      exp_cyc = n + 1 + nb * (wait_states + 1);
      wait_rsp(got);
      checks++;
      if (beat_adr_q.size() != nb) $display("FAIL rnd%0d_beats: %0d, required %0d", it, beat_adr_q.size(), nb);
      else passed++;
      for (int i = 0; i < nb && i < beat_adr_q.size(); i++) begin
        logic [31:0] ea;
        ea = exp_q.pop_front();
        checks++;
        if (beat_adr_q[i] !== ea || beat_we_q[i] !== w || (w && beat_dat_q[i] !== line[32*i +: 32]))
          $display("FAIL rnd%0d_beat%0d: adr=%h we=%b dat=%h, required adr=%h we=%b dat=%h",
                   it, i, beat_adr_q[i], beat_we_q[i], beat_dat_q[i], ea, w, line[32*i +: 32]);
        else passed++;
      end
      checks++;
      if (!got || rsp_cyc_q.size() != 1 || rsp_cyc_q[0] != exp_cyc)
        $display("FAIL rnd%0d_timing: count=%0d at N+%0d, required one at N+%0d",
                 it, rsp_cyc_q.size(), got ? rsp_cyc_q[0] - n : -1, exp_cyc - n);
      else passed++;
      checks++;
      if (!got || rsp_dat_q[0] !== exp_data || rsp_err_q[0] !== exp_err)
        $display("FAIL rnd%0d_rsp: data=%h err=%b, required data=%h err=%b",
                 it, got ? rsp_dat_q[0] : 128'h0, got ? rsp_err_q[0] : 1'b0, exp_data, exp_err);
      else passed++;
    end
    err_beat = -1; wait_states = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_info  = '0;
    for (int k = 0; k < 4; k++) rd_words[k] = '0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_err_beat();
    test_timeout();
    test_reset_mid();
    test_ignore_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
